// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames).
// The SPI pins are oversampled in the system clock domain. Edges are found by
// comparing the synchronized sample with the previous one and are then
// registered once more, so every action happens one cycle after detection.
// A single-entry transmit buffer feeds the miso shift register through a
// valid/ready handshake.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       ss_n_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       underrun_o,
    output logic       busy_o
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Synchronizer chains; the last stage is the usable sample.
    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic [SYNC_STAGES-1:0] ssSync_q;

    logic sclkNow;
    logic mosiNow;
    logic ssNow;

    // Previous samples and registered edge strobes.
    logic sclkPrev_q;
    logic ssPrev_q;
    logic mosiAligned_q;
    logic sclkRise_q;
    logic sclkFall_q;
    logic ssFall_q;
    logic ssRise_q;

    // Protocol state.
    state_t     state_q,    state_d;
    logic [7:0] txShift_q,  txShift_d;
    logic [7:0] rxShift_q,  rxShift_d;
    logic [2:0] bitCnt_q,   bitCnt_d;
    logic       byteEnd_q,  byteEnd_d;
    logic       bufValid_q, bufValid_d;
    logic [7:0] bufData_q,  bufData_d;
    logic [7:0] rxData_q,   rxData_d;
    logic       rxValid_q,  rxValid_d;
    logic       underrun_q, underrun_d;

    logic       loadShift;
    logic       txAccept;

    assign sclkNow = sclkSync_q[SYNC_STAGES-1];
    assign mosiNow = mosiSync_q[SYNC_STAGES-1];
    assign ssNow   = ssSync_q[SYNC_STAGES-1];

    // Shift the raw pins through the synchronizer chains; ss_n idles high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclkSync_q <= '0;
            mosiSync_q <= '0;
            ssSync_q   <= '1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_i};
            ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], ss_n_i};
        end
    end

    // Detect edges on the synchronized pins and register them, keeping mosi
    // aligned with the sclk edge strobe that will consume it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclkPrev_q    <= 1'b0;
            ssPrev_q      <= 1'b1;
            mosiAligned_q <= 1'b0;
            sclkRise_q    <= 1'b0;
            sclkFall_q    <= 1'b0;
            ssFall_q      <= 1'b0;
            ssRise_q      <= 1'b0;
        end else begin
            sclkPrev_q    <= sclkNow;
            ssPrev_q      <= ssNow;
            mosiAligned_q <= mosiNow;
            sclkRise_q    <= sclkNow & ~sclkPrev_q;
            sclkFall_q    <= ~sclkNow & sclkPrev_q;
            ssFall_q      <= ~ssNow & ssPrev_q;
            ssRise_q      <= ssNow & ~ssPrev_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            txShift_q  <= 8'h00;
            rxShift_q  <= 8'h00;
            bitCnt_q   <= 3'd0;
            byteEnd_q  <= 1'b0;
            bufValid_q <= 1'b0;
            bufData_q  <= 8'h00;
            rxData_q   <= 8'h00;
            rxValid_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            txShift_q  <= txShift_d;
            rxShift_q  <= rxShift_d;
            bitCnt_q   <= bitCnt_d;
            byteEnd_q  <= byteEnd_d;
            bufValid_q <= bufValid_d;
            bufData_q  <= bufData_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic: frame control, bit shifting, buffer load and refill.
    always_comb begin
        state_d    = state_q;
        txShift_d  = txShift_q;
        rxShift_d  = rxShift_q;
        bitCnt_d   = bitCnt_q;
        byteEnd_d  = byteEnd_q;
        bufValid_d = bufValid_q;
        bufData_d  = bufData_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        underrun_d = 1'b0;
        loadShift  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ssFall_q) begin
                    loadShift = 1'b1;
                    bitCnt_d  = 3'd0;
                    rxShift_d = 8'h00;
                    byteEnd_d = 1'b0;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ssRise_q) begin
                    // Deselect wins over any sclk edge seen in the same cycle.
                    bitCnt_d  = 3'd0;
                    byteEnd_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    if (sclkRise_q) begin
                        rxShift_d = {rxShift_q[6:0], mosiAligned_q};
                        if (bitCnt_q == 3'd7) begin
                            rxData_d  = {rxShift_q[6:0], mosiAligned_q};
                            rxValid_d = 1'b1;
                            bitCnt_d  = 3'd0;
                            byteEnd_d = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                    if (sclkFall_q) begin
                        if (byteEnd_q) begin
                            byteEnd_d = 1'b0;
                            loadShift = 1'b1;
                        end else begin
                            txShift_d = {txShift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load takes the buffered byte, or sends zeros and flags underrun.
        if (loadShift) begin
            if (bufValid_q) begin
                txShift_d  = bufData_q;
                bufValid_d = 1'b0;
            end else begin
                txShift_d  = 8'h00;
                underrun_d = 1'b1;
            end
        end

        // A write can only be accepted into an empty buffer, so a load in the
        // same cycle has already seen it empty and the write still lands.
        if (txAccept) begin
            bufValid_d = 1'b1;
            bufData_d  = tx_data_i;
        end
    end

    assign txAccept   = tx_valid_i & ~bufValid_q;
    assign tx_ready_o = ~bufValid_q;
    assign miso_oe_o  = (state_q == ACTIVE);
    assign miso_o     = (state_q == ACTIVE) ? txShift_q[7] : 1'b0;
    assign busy_o     = (state_q == ACTIVE);
    assign rx_data_o  = rxData_q;
    assign rx_valid_o = rxValid_q;
    assign underrun_o = underrun_q;

endmodule
